// File: rtl/kgp_pc_pkg.sv
// Shared types and constants for the KGP_RISC program-counter stage.
package kgp_pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        SEQ = 2'd0,
        BR  = 2'd1,
        J   = 2'd2,
        JR  = 2'd3
    } pc_sel_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: sequential, branch and direct-jump targets.
module pc_target_calc
    import kgp_pc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] shifted_offset,
    input  logic [25:0] jump_index,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic [31:0] jump_addr
);

    // Modulo-2^32 adds: negative offsets and the top-of-memory wrap fall out naturally.
    assign pc_plus4      = pc + PC_STEP;
    assign branch_target = pc_plus4 + shifted_offset;
    assign jump_addr     = {pc_plus4[31:28], jump_index, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: BOOT/RUN/HALTED control, redirect priority and the PC register.
module pc_sequencer
    import kgp_pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter bit          ALIGN_CHECK  = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ShiftedOffset,
    input  logic        BranchTaken,
    input  logic        JumpEn,
    input  logic [25:0] JumpTarget,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
    input  logic        Halt,
    input  logic        FetchReady,
    output logic        FetchValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Halted,
    output logic        AlignFault
);

    pc_state_t   state_q, state_d;
    pc_sel_t     sel;
    logic        pc_load;
    logic        fault_set;
    logic        accept;
    logic [31:0] pc_q, pc_d;
    logic [31:0] branch_target, jump_addr;
    logic        fault_q;

    pc_target_calc u_target_calc (
        .pc             (pc_q),
        .shifted_offset (ShiftedOffset),
        .jump_index     (JumpTarget),
        .pc_plus4       (PCPlus4),
        .branch_target  (branch_target),
        .jump_addr      (jump_addr)
    );

    assign FetchValid = (state_q == RUN);
    assign accept     = FetchValid & FetchReady;

    always_comb begin
        state_d   = state_q;
        sel       = SEQ;
        pc_load   = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                // Redirects load regardless of FetchReady; only plain sequencing waits on accept.
                if (JumpReg) begin
                    sel     = JR;
                    pc_load = 1'b1;
                    if (ALIGN_CHECK && (RegTarget[1:0] != 2'b00)) begin
                        fault_set = 1'b1;
                        state_d   = HALTED;
                    end
                end else if (JumpEn) begin
                    sel     = J;
                    pc_load = 1'b1;
                end else if (BranchTaken) begin
                    sel     = BR;
                    pc_load = 1'b1;
                end else if (accept) begin
                    sel     = SEQ;
                    pc_load = 1'b1;
                end
                if (accept && Halt) begin
                    state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            case (sel)
                SEQ:     pc_d = PCPlus4;
                BR:      pc_d = branch_target;
                J:       pc_d = jump_addr;
                JR:      pc_d = {RegTarget[31:2], 2'b00};
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (fault_set) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign PC         = pc_q;
    assign Halted     = (state_q == HALTED);
    assign AlignFault = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] ShiftedOffset;
    logic        BranchTaken;
    logic        JumpEn;
    logic [25:0] JumpTarget;
    logic        JumpReg;
    logic [31:0] RegTarget;
    logic        Halt;
    logic        FetchReady;
    logic        FetchValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Halted;
    logic        AlignFault;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .ALIGN_CHECK  (1'b1)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ShiftedOffset (ShiftedOffset),
        .BranchTaken   (BranchTaken),
        .JumpEn        (JumpEn),
        .JumpTarget    (JumpTarget),
        .JumpReg       (JumpReg),
        .RegTarget     (RegTarget),
        .Halt          (Halt),
        .FetchReady    (FetchReady),
        .FetchValid    (FetchValid),
        .PC            (PC),
        .PCPlus4       (PCPlus4),
        .Halted        (Halted),
        .AlignFault    (AlignFault)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        ShiftedOffset = '0;
        BranchTaken   = 1'b0;
        JumpEn        = 1'b0;
        JumpTarget    = '0;
        JumpReg       = 1'b0;
        RegTarget     = '0;
        Halt          = 1'b0;
        FetchReady    = 1'b1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #3;
        Reset = 1'b0;
    endtask

    task automatic jump_to(input logic [25:0] idx);
        JumpEn     = 1'b1;
        JumpTarget = idx;
        step();
        JumpEn     = 1'b0;
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;
        #12;
        check("rst_pc", PC, 32'h0);
        check("rst_fv", {31'b0, FetchValid}, 32'h0);
        check("rst_halted", {31'b0, Halted}, 32'h0);
        check("rst_af", {31'b0, AlignFault}, 32'h0);
        check("rst_pc4", PCPlus4, 32'h4);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Boot cycle, then sequential fetch 0,4,8,12.
        check("boot_fv", {31'b0, FetchValid}, 32'h0);
        step();
        check("run_fv", {31'b0, FetchValid}, 32'h1);
        check("seq0", PC, 32'h0);
        step(); check("seq4", PC, 32'h4);
        step(); check("seq8", PC, 32'h8);
        step(); check("seq12", PC, 32'hC);

        // Stall at 0x100.
        jump_to(26'h40);
        check("jmp100", PC, 32'h100);
        FetchReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", PC, 32'h100);
            check("stall_fv", {31'b0, FetchValid}, 32'h1);
        end
        FetchReady = 1'b1;
        step();
        check("stall_release", PC, 32'h104);

        // Negative branch from 0x200, with FetchReady low to show redirect beats stall.
        jump_to(26'h80);
        check("jmp200", PC, 32'h200);
        FetchReady    = 1'b0;
        BranchTaken   = 1'b1;
        ShiftedOffset = 32'hFFFF_FFF0;
        step();
        check("br_neg", PC, 32'h1F4);
        BranchTaken = 1'b0;
        FetchReady  = 1'b1;

        // Jump beats branch.
        jump_to(26'h80);
        check("jmp200b", PC, 32'h200);
        BranchTaken   = 1'b1;
        ShiftedOffset = 32'hFFFF_FFF0;
        JumpEn        = 1'b1;
        JumpTarget    = 26'h40;
        step();
        check("j_over_br", PC, 32'h100);
        BranchTaken = 1'b0;

        // Jump-register beats jump (aligned, no fault).
        JumpReg   = 1'b1;
        RegTarget = 32'h0000_0300;
        step();
        check("jr_over_j", PC, 32'h300);
        check("jr_ok_af", {31'b0, AlignFault}, 32'h0);
        JumpEn = 1'b0;

        // Misaligned jump-register.
        RegTarget = 32'h0000_0302;
        step();
        check("jr_mis_pc", PC, 32'h300);
        check("jr_mis_af", {31'b0, AlignFault}, 32'h1);
        check("jr_mis_halt", {31'b0, Halted}, 32'h1);
        check("jr_mis_fv", {31'b0, FetchValid}, 32'h0);
        JumpReg    = 1'b0;
        JumpEn     = 1'b1;
        JumpTarget = 26'h10;
        step();
        check("halted_hold", PC, 32'h300);
        check("halted_fv", {31'b0, FetchValid}, 32'h0);
        JumpEn = 1'b0;
        do_reset();
        check("af_clear", {31'b0, AlignFault}, 32'h0);
        check("halt_clear", {31'b0, Halted}, 32'h0);
        check("pc_clear", PC, 32'h0);

        // Top-of-memory wrap, then halt handling.
        step();
        JumpReg   = 1'b1;
        RegTarget = 32'hFFFF_FFFC;
        step();
        JumpReg = 1'b0;
        check("jr_top", PC, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", PC, 32'h0);
        check("wrap_af", {31'b0, AlignFault}, 32'h0);
        Halt       = 1'b1;
        FetchReady = 1'b0;
        step();
        check("halt_noacc", {31'b0, Halted}, 32'h0);
        check("halt_noacc_pc", PC, 32'h0);
        FetchReady = 1'b1;
        step();
        check("halt_acc", {31'b0, Halted}, 32'h1);
        check("halt_acc_pc", PC, 32'h4);
        Halt = 1'b0;
        step();
        check("halt_hold", PC, 32'h4);

        // Halt together with a redirect on an accept: target loads, then halts.
        do_reset();
        step();
        Halt       = 1'b1;
        JumpEn     = 1'b1;
        JumpTarget = 26'h20;
        step();
        check("halt_redir_pc", PC, 32'h80);
        check("halt_redir_h", {31'b0, Halted}, 32'h1);
        Halt   = 1'b0;
        JumpEn = 1'b0;

        // Asynchronous reset between edges.
        do_reset();
        step();
        jump_to(26'h10);
        check("pre_async", PC, 32'h40);
        #2;
        Reset = 1'b1;
        #1;
        check("async_pc", PC, 32'h0);
        check("async_fv", {31'b0, FetchValid}, 32'h0);
        Reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
